defuzz_centroid: RTL and testbench

DEFUZZ_CENTROID -- requirements
Module: defuzz_centroid

---
 rtl/defuzz_pkg.sv | 23 ++
 rtl/defuzz_seq_div.sv | 67 ++++++
 rtl/defuzz_centroid.sv | 134 +++++++++++++
 tb/tb_defuzz_centroid.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/defuzz_pkg.sv
// Shared types and helpers for the centroid defuzzifier: FSM states, divider width, reset table contents.
// Used by defuzz_centroid and defuzz_seq_div.
package defuzz_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MAC,
    DIV,
    DONE
  } state_t;

  // Signed product of a centroid and a zero-extended weight, plus one carry bit for the two-term sum
  function automatic int div_width(input int out_w, input int mu_w);
    return out_w + mu_w + 1;
  endfunction

  // Positive centroids above the middle set, negative below; no entry is zero
  function automatic int default_centroid(input int k);
    return (k < 8) ? (8 - k) : (7 - k);
  endfunction

endpackage

// File: rtl/defuzz_seq_div.sv
// Unsigned restoring divider, one quotient bit per cycle; o_done pulses D_W cycles after i_start.
// No backpressure: i_start restarts the divider whenever it is asserted.
module defuzz_seq_div #(
  parameter int D_W = 17,
  parameter int S_W = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [D_W-1:0] i_dividend,
  input  logic [S_W-1:0] i_divisor,
  output logic           o_busy,
  output logic           o_done,
  output logic [D_W-1:0] o_quot
);

  localparam int CNT_W = $clog2(D_W + 1);

  logic [S_W-1:0]   r_rem;
  logic [D_W-1:0]   r_quot;
  logic [S_W-1:0]   r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [S_W:0]     w_shift;
  logic [S_W-1:0]   w_diff;
  logic             w_ge;

  // Remainder stays below the divisor, so the low S_W bits of the difference are exact
  assign w_shift = {r_rem, r_quot[D_W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift[S_W-1:0] - r_div;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= '0;
        r_quot <= i_dividend;
        r_div  <= i_divisor;
        r_cnt  <= CNT_W'(D_W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem  <= w_ge ? w_diff : w_shift[S_W-1:0];
        r_quot <= {r_quot[D_W-2:0], w_ge};
        r_cnt  <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_quot = r_quot;

endmodule

// File: rtl/defuzz_centroid.sv
// Two-set weighted-centroid defuzzifier with a writable centroid table; fixed 3+D cycle latency.
// One request in flight: in_ready only in IDLE, result held in DONE until out_ready.
module defuzz_centroid
  import defuzz_pkg::*;
#(
  parameter int N_LEVELS = 17,
  parameter int OUT_W    = 8,
  parameter int MU_W     = 8,
  parameter int IDX_W    = $clog2(N_LEVELS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IDX_W-1:0]        idx_a,
  input  logic [IDX_W-1:0]        idx_b,
  input  logic [MU_W-1:0]         mu_a,
  input  logic [MU_W-1:0]         mu_b,
  input  logic                    tbl_we,
  input  logic [IDX_W-1:0]        tbl_addr,
  input  logic signed [OUT_W-1:0] tbl_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] df,
  output logic                    zero_w
);

  localparam int D   = div_width(OUT_W, MU_W);
  localparam int S_W = MU_W + 1;

  state_t r_state, w_next;

  logic [IDX_W-1:0]        r_idx_a, r_idx_b;
  logic [MU_W-1:0]         r_mu_a, r_mu_b;
  logic signed [OUT_W-1:0] r_c_a, r_c_b;
  logic signed [OUT_W-1:0] r_tbl [N_LEVELS];
  logic                    r_neg;
  logic                    r_sum_zero;
  logic signed [OUT_W-1:0] r_df;
  logic                    r_zero_w;

  logic signed [D-1:0]     w_ca_x, w_cb_x, w_mua_x, w_mub_x, w_num, w_res;
  logic [S_W-1:0]          w_sum;
  logic [D-1:0]            w_mag, w_dividend, w_quot;
  logic                    w_div_busy, w_div_done, w_div_start;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = LOOKUP;
      LOOKUP:  w_next = MAC;
      MAC:     w_next = DIV;
      DIV:     if (w_div_done && !w_div_busy) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign w_div_start = (r_state == MAC);

  assign w_ca_x  = D'(r_c_a);
  assign w_cb_x  = D'(r_c_b);
  assign w_mua_x = D'({1'b0, r_mu_a});
  assign w_mub_x = D'({1'b0, r_mu_b});
  assign w_num   = w_ca_x * w_mua_x + w_cb_x * w_mub_x;
  assign w_sum   = {1'b0, r_mu_a} + {1'b0, r_mu_b};

  // Adding half the divisor before truncating rounds the magnitude half-up, i.e. away from zero
  assign w_mag      = w_num[D-1] ? -w_num : w_num;
  assign w_dividend = w_mag + D'(w_sum >> 1);
  assign w_res      = r_neg ? -$signed(w_quot) : $signed(w_quot);

  defuzz_seq_div #(
    .D_W (D),
    .S_W (S_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (w_dividend),
    .i_divisor  (w_sum),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quot     (w_quot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_LEVELS; k++) r_tbl[k] <= OUT_W'(default_centroid(k));
      r_idx_a    <= '0;
      r_idx_b    <= '0;
      r_mu_a     <= '0;
      r_mu_b     <= '0;
      r_c_a      <= '0;
      r_c_b      <= '0;
      r_neg      <= 1'b0;
      r_sum_zero <= 1'b0;
      r_df       <= '0;
      r_zero_w   <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        r_idx_a <= idx_a;
        r_idx_b <= idx_b;
        r_mu_a  <= mu_a;
        r_mu_b  <= mu_b;
      end
      if (tbl_we && (32'(tbl_addr) < N_LEVELS)) r_tbl[tbl_addr] <= tbl_data;
      // Reads see the table contents before any write landing on the same edge
      if (r_state == LOOKUP) begin
        r_c_a <= (32'(r_idx_a) < N_LEVELS) ? r_tbl[r_idx_a] : OUT_W'(1);
        r_c_b <= (32'(r_idx_b) < N_LEVELS) ? r_tbl[r_idx_b] : OUT_W'(1);
      end
      if (r_state == MAC) begin
        r_neg      <= w_num[D-1];
        r_sum_zero <= (w_sum == '0);
      end
      if ((r_state == DIV) && (w_next == DONE)) begin
        r_df     <= r_sum_zero ? '0 : OUT_W'(w_res);
        r_zero_w <= r_sum_zero;
      end
    end
  end

  assign df     = r_df;
  assign zero_w = r_zero_w;

endmodule

// File: tb/tb_defuzz_centroid.sv
// Directed bench for defuzz_centroid: latency, rounding, zero weight, stalls, table writes, resets.
module tb_defuzz_centroid;

  localparam int N_LEVELS = 17;
  localparam int OUT_W    = 8;
  localparam int MU_W     = 8;
  localparam int IDX_W    = 5;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [IDX_W-1:0]        idx_a, idx_b;
  logic [MU_W-1:0]         mu_a, mu_b;
  logic                    tbl_we;
  logic [IDX_W-1:0]        tbl_addr;
  logic signed [OUT_W-1:0] tbl_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] df;
  logic                    zero_w;

  int errors = 0;
  int checks = 0;
  int lat;
  int seen;

  defuzz_centroid #(
    .N_LEVELS (N_LEVELS),
    .OUT_W    (OUT_W),
    .MU_W     (MU_W),
    .IDX_W    (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .idx_a     (idx_a),
    .idx_b     (idx_b),
    .mu_a      (mu_a),
    .mu_b      (mu_b),
    .tbl_we    (tbl_we),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .df        (df),
    .zero_w    (zero_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tbl_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ia, input int ma, input int ib, input int mb);
    @(negedge clk);
    chk("in_ready_before_send", in_ready, 1);
    idx_a = IDX_W'(ia); mu_a = MU_W'(ma);
    idx_b = IDX_W'(ib); mu_b = MU_W'(mb);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic tbl_write(input int addr, input int data);
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = IDX_W'(addr); tbl_data = OUT_W'(data);
    @(posedge clk);
    #1 tbl_we = 1'b0;
  endtask

  // Counts rising edges since the accept edge until out_valid, bounded
  task automatic wait_out(input int start);
    lat = start;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic finish_txn(input string tag, input int edf, input int ezw);
    chk({tag, "_latency"}, lat, 20);
    chk({tag, "_df"}, $signed(df), edf);
    chk({tag, "_zero_w"}, zero_w, ezw);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, out_valid, 0);
    chk({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tbl_we = 1'b0;
    idx_a = '0; idx_b = '0; mu_a = '0; mu_b = '0; tbl_addr = '0; tbl_data = '0;

    do_reset();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_df", $signed(df), 0);
    chk("reset_zero_w", zero_w, 0);

    // 8*255 / 255
    send(0, 255, 1, 0); wait_out(0); finish_txn("single_set", 8, 0);
    // (5*100 + 4*50) / 150 = 4.67
    send(3, 100, 4, 50); wait_out(0); finish_txn("round_up", 5, 0);
    // (-2 - 3) / 2 = -2.5
    send(9, 1, 10, 1); wait_out(0); finish_txn("neg_half", -3, 0);
    send(0, 0, 0, 0); wait_out(0); finish_txn("zero_weight", 0, 1);
    // Out-of-range index reads +1; out-of-range write must not disturb anything
    tbl_write(20, 50);
    send(20, 10, 5, 0); wait_out(0); finish_txn("oob_index", 1, 0);

    // Stall in DONE: (6*10 + 6*10) / 20 = 6
    send(2, 10, 2, 10); wait_out(0);
    chk("stall_latency", lat, 20);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_df", $signed(df), 6);
      chk("stall_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("stall_in_ready_after_release", in_ready, 1);
    // (-9*3 + -8*1) / 4 = -8.75
    send(16, 3, 15, 1); wait_out(0); finish_txn("back_to_back", -9, 0);

    // Write to tbl[5] on the lookup edge: lookup uses the old value 3
    send(5, 1, 5, 1);
    tbl_we = 1'b1; tbl_addr = IDX_W'(5); tbl_data = -8'sd7;
    @(posedge clk);
    #1 tbl_we = 1'b0;
    wait_out(1); finish_txn("collision_old", 3, 0);
    send(5, 1, 5, 1); wait_out(0); finish_txn("collision_new", -7, 0);

    // (-20*4 + -1*4) / 8 = -10.5
    tbl_write(7, -20);
    send(7, 4, 8, 4); wait_out(0); finish_txn("written_entry", -11, 0);
    do_reset();
    send(7, 4, 8, 4); wait_out(0); finish_txn("table_reloaded", 0, 0);

    // Abort during DIV
    send(0, 100, 1, 100);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    chk("abort_no_result", seen, 0);
    // (7*50 + 7*50) / 100 = 7
    send(1, 50, 1, 50); wait_out(0); finish_txn("after_abort", 7, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
